// File: rtl/quad_decoder_if.sv
// Quadrature decoder bus: encoder phases, index and clear in; position, direction, status out.
interface quad_decoder_if #(
  parameter int WIDTH = 16
);
  logic             a;
  logic             b;
  logic             z;
  logic             clr;
  logic [WIDTH-1:0] cnt;
  logic             dir;
  logic             step;
  logic             err;
  logic [WIDTH-1:0] idx_cnt;
  logic             idx_valid;

  modport master (
    output a, b, z, clr,
    input  cnt, dir, step, err, idx_cnt, idx_valid
  );

  modport slave (
    input  a, b, z, clr,
    output cnt, dir, step, err, idx_cnt, idx_valid
  );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronised, glitch-filtered A/B/Z inputs drive a signed
// position counter with direction, step pulse, sticky skip error and index capture.
module quad_decoder #(
  parameter int WIDTH      = 16,
  parameter int FILTER     = 2,
  parameter int INDEX_MODE = 1
) (
  input logic           clk,
  input logic           reset,
  quad_decoder_if.slave bus
);

  localparam logic [3:0] F_LAST     = 4'(FILTER - 1);
  localparam logic [4:0] PRIME_LAST = 5'(FILTER + 2);

  logic [2:0]       w_in;
  logic [2:0]       r_s1;
  logic [2:0]       r_s2;
  logic [2:0]       r_filt;
  logic [3:0]       r_fcnt [3];
  logic [4:0]       r_pcnt;
  logic             r_primed;
  logic             r_pa;
  logic             r_pb;
  logic             r_pz;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_idx_cnt;
  logic             r_dir;
  logic             r_step;
  logic             r_err;
  logic             r_idx_valid;
  logic             w_da;
  logic             w_db;
  logic             w_fwd;
  logic             w_zrise;
  logic [WIDTH-1:0] w_cnt_ph;

  assign w_in = {bus.z, bus.b, bus.a};

  // Bit 0 = a, bit 1 = b, bit 2 = z; each gets its own two-flop sync and level filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_filt <= '0;
      for (int unsigned i = 0; i < 3; i++) r_fcnt[i] <= '0;
    end else begin
      r_s1 <= w_in;
      r_s2 <= r_s1;
      for (int unsigned i = 0; i < 3; i++) begin
        if (r_s2[i] != r_filt[i]) begin
          if (r_fcnt[i] == F_LAST) begin
            r_filt[i] <= r_s2[i];
            r_fcnt[i] <= '0;
          end else begin
            r_fcnt[i] <= r_fcnt[i] + 4'd1;
          end
        end else begin
          r_fcnt[i] <= '0;
        end
      end
    end
  end

  // Decoding stays off until the filters have reached the live input level and the
  // previous-sample registers have caught up, so release never produces a phantom step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt   <= '0;
      r_primed <= 1'b0;
    end else if (!r_primed) begin
      if (r_pcnt == PRIME_LAST) r_primed <= 1'b1;
      else                      r_pcnt   <= r_pcnt + 5'd1;
    end
  end

  assign w_da    = r_filt[0] ^ r_pa;
  assign w_db    = r_filt[1] ^ r_pb;
  assign w_fwd   = r_filt[1] ^ r_pa;
  assign w_zrise = (INDEX_MODE == 1 || INDEX_MODE == 2) && r_filt[2] && !r_pz;

  always_comb begin
    w_cnt_ph = r_cnt;
    if (w_da ^ w_db)      w_cnt_ph = w_fwd ? r_cnt + WIDTH'(1) : r_cnt - WIDTH'(1);
    else if (w_da & w_db) w_cnt_ph = r_dir ? r_cnt + WIDTH'(2) : r_cnt - WIDTH'(2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pa        <= 1'b0;
      r_pb        <= 1'b0;
      r_pz        <= 1'b0;
      r_cnt       <= '0;
      r_idx_cnt   <= '0;
      r_dir       <= 1'b0;
      r_step      <= 1'b0;
      r_err       <= 1'b0;
      r_idx_valid <= 1'b0;
    end else begin
      r_pa        <= r_filt[0];
      r_pb        <= r_filt[1];
      r_pz        <= r_filt[2];
      r_step      <= 1'b0;
      r_idx_valid <= 1'b0;
      if (r_primed) begin
        if (w_da ^ w_db) begin
          r_dir  <= w_fwd;
          r_step <= 1'b1;
        end else if (w_da & w_db) begin
          r_step <= 1'b1;
          r_err  <= 1'b1;
        end
        r_cnt <= w_cnt_ph;
        if (w_zrise) begin
          r_idx_cnt   <= r_cnt;
          r_idx_valid <= 1'b1;
          if (INDEX_MODE == 1) r_cnt <= '0;
        end
      end
      // Clear wins over index and phase updates, including the sticky error.
      if (bus.clr) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end
    end
  end

  assign bus.cnt       = r_cnt;
  assign bus.dir       = r_dir;
  assign bus.step      = r_step;
  assign bus.err       = r_err;
  assign bus.idx_cnt   = r_idx_cnt;
  assign bus.idx_valid = r_idx_valid;

endmodule
